// File: rtl/memmatrix_pkg.sv
// Shared definitions for the Memory Matrix game.
// Holds the default board/round constants and the 3-bit state encoding used
// by the controller; the board generator and display logic import the same
// constants so every block agrees on board size and timing.
package memmatrix_pkg;

  localparam int unsigned CELLS_DEF       = 16;
  localparam int unsigned MAX_GUESSES_DEF = 3;
  localparam int unsigned SHOW_CYCLES_DEF = 100_000_000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GEN   = 3'd1;
  localparam logic [2:0] ST_SHOW  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_WIN   = 3'd5;
  localparam logic [2:0] ST_LOSE  = 3'd6;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter used to time the memorize phase.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   load        - load the counter with value (takes priority)
//   value       - count to load
//   done        - high in the last counted cycle (count is 1); the counter
//                 reaches 0 on the following edge and then holds there
module phase_timer #(
  parameter int unsigned WIDTH = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == WIDTH'(1));

endmodule

// File: rtl/game_controller.sv
// Round-sequencing FSM for the Memory Matrix game.
// Requests a board, shows it for SHOW_CYCLES, then scores one guess at a time
// against the latched board until every set cell is found (win) or the wrong
// guess allowance runs out (lose).
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   start               - begin a round from IDLE/WIN/LOSE
//   board, board_ready  - generator output and its valid flag
//   guess_valid, guess_idx - guess handshake (taken when guess_ready)
//   gen_req             - one-cycle request for a new board
//   show                - display latched board (memorize and result phases)
//   guess_ready         - a guess is accepted this cycle
//   found               - correctly guessed cells this round
//   remaining           - wrong guesses left
//   win, lose           - round result, held until the next round
//   state               - current FSM state (debug)
module game_controller
  import memmatrix_pkg::*;
#(
  parameter int unsigned CELLS       = CELLS_DEF,
  parameter int unsigned IDX_W       = $clog2(CELLS),
  parameter int unsigned MAX_GUESSES = MAX_GUESSES_DEF,
  parameter int unsigned GUESS_W     = $clog2(MAX_GUESSES + 1),
  parameter int unsigned SHOW_CYCLES = SHOW_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CELLS-1:0]   board,
  input  logic               board_ready,
  input  logic               guess_valid,
  input  logic [IDX_W-1:0]   guess_idx,
  output logic               gen_req,
  output logic               show,
  output logic               guess_ready,
  output logic [CELLS-1:0]   found,
  output logic [GUESS_W-1:0] remaining,
  output logic               win,
  output logic               lose,
  output logic [2:0]         state
);

  localparam int unsigned TIMER_W = $clog2(SHOW_CYCLES + 1);

  logic [2:0]       state_q;
  logic [CELLS-1:0] board_q;
  logic [IDX_W-1:0] guess_q;
  logic             timer_load;
  logic             timer_done;
  logic             board_ok;
  logic             guess_in_range;
  logic [CELLS-1:0] guess_mask;
  logic             guess_hit;
  logic             guess_repeat;
  logic [CELLS-1:0] found_after;

  assign board_ok   = board_ready && (board != '0);
  assign timer_load = (state_q == ST_GEN) && board_ok;

  phase_timer #(
    .WIDTH(TIMER_W)
  ) u_show_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (TIMER_W'(SHOW_CYCLES)),
    .done  (timer_done)
  );

  // Decode the registered guess into a one-hot cell mask; an out-of-range
  // index yields an empty mask, which scores as neither hit nor miss.
  always_comb begin
    guess_in_range = (32'(guess_q) < CELLS);
    guess_mask     = '0;
    if (guess_in_range) begin
      guess_mask = CELLS'(1) << guess_q;
    end
    guess_hit    = |(guess_mask & board_q);
    guess_repeat = |(guess_mask & found);
    found_after  = found | guess_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      board_q   <= '0;
      guess_q   <= '0;
      gen_req   <= 1'b0;
      found     <= '0;
      remaining <= GUESS_W'(MAX_GUESSES);
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      gen_req <= 1'b0;
      case (state_q)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start) begin
            state_q   <= ST_GEN;
            gen_req   <= 1'b1;
            found     <= '0;
            remaining <= GUESS_W'(MAX_GUESSES);
            win       <= 1'b0;
            lose      <= 1'b0;
          end
        end
        ST_GEN: begin
          if (board_ready) begin
            board_q <= board;
            if (board_ok) begin
              state_q <= ST_SHOW;
            end else begin
              // Empty board is unplayable: ask again without leaving GEN.
              gen_req <= 1'b1;
            end
          end
        end
        ST_SHOW: begin
          if (timer_done) begin
            state_q <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (guess_valid) begin
            guess_q <= guess_idx;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_q <= ST_PLAY;
          if (!guess_in_range) begin
            state_q <= ST_PLAY;
          end else if (guess_hit) begin
            if (!guess_repeat) begin
              found <= found_after;
              if (found_after == board_q) begin
                state_q <= ST_WIN;
                win     <= 1'b1;
              end
            end
          end else if (remaining != '0) begin
            remaining <= remaining - GUESS_W'(1);
            if (remaining == GUESS_W'(1)) begin
              state_q <= ST_LOSE;
              lose    <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign show        = (state_q == ST_SHOW) || (state_q == ST_WIN) || (state_q == ST_LOSE);
  assign guess_ready = (state_q == ST_PLAY);
  assign state       = state_q;

endmodule

// File: doc/game_controller.md
# game_controller

Round-sequencing FSM for the Memory Matrix game. Sits between the top level (switches/keys) and the board datapath. It requests a new board, shows it for a fixed memorize interval, accepts cell guesses one at a time, scores each guess against the latched board, tracks remaining wrong guesses, and declares win or lose. It owns the found-cell mask and the remaining-guess count; the board generator is external.

## Interface
- `CELLS`, 16, number of board cells (one bit per cell).
- `IDX_W`, $clog2(CELLS), guess index width.
- `MAX_GUESSES`, 3, wrong guesses allowed per round (≥1).
- `GUESS_W`, $clog2(MAX_GUESSES+1), remaining-count width.
- `SHOW_CYCLES`, 100_000_000, memorize interval in clk cycles (2 s at 50 MHz; ≥1).
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level, synchronous; begins a round from IDLE/WIN/LOSE.
- `board` in CELLS: generator output, valid when `board_ready`=1.
- `board_ready` in 1: generator has a board.
- `guess_valid` in 1: guess present on `guess_idx`.
- `guess_idx` in IDX_W: guessed cell index.
- `gen_req` out 1: one-cycle pulse asking generator for a new board.
- `show` out 1: display latched board (memorize phase).
- `guess_ready` out 1: controller accepts a guess this cycle.
- `found` out CELLS: correctly guessed cells this round.
- `remaining` out GUESS_W: wrong guesses left.
- `win`, `lose` out 1: round result, held until next round/reset.
- `state` out 3: current FSM state, debug.

## Operation
- States: IDLE, GEN, SHOW, PLAY, CHECK, WIN, LOSE.
- IDLE: on `start`, go to GEN; clear `found`, load `remaining`=MAX_GUESSES, clear `win`/`lose`.
- GEN: `gen_req` pulses on the entry cycle only. When `board_ready`=1, latch `board`:
  - nonzero board: go to SHOW, load the timer with SHOW_CYCLES;
  - all-zero board: discard it, stay in GEN and re-pulse `gen_req` next cycle.
- SHOW: `show`=1; timer decrements each cycle. When the count hits 0, go to PLAY.
- PLAY: `guess_ready`=1. A guess is accepted when `guess_valid`&`guess_ready`; register the index and go to CHECK.
- CHECK (single cycle), then:
  - idx ≥ CELLS: no effect, back to PLAY.
  - latched bit set, `found` bit clear: set the `found` bit. If `found`==board afterwards, go to WIN, else PLAY.
  - latched bit set, `found` bit already set: repeat guess, no penalty, back to PLAY.
  - latched bit clear: `remaining` -= 1. If it was 1 (becomes 0), go to LOSE, else PLAY.
- WIN/LOSE: assert `win`/`lose`; `show`=1 (reveal board). On `start`, behave as IDLE→GEN with the same clears.
- `start` is ignored in GEN, SHOW, PLAY and CHECK. `guess_valid` is ignored outside PLAY.
- `remaining` never underflows; it saturates at 0 in LOSE.

## Timing
- Reset values: state=IDLE, `gen_req`=0, `show`=0, `guess_ready`=0, `found`=0, `remaining`=MAX_GUESSES, `win`=0, `lose`=0, latched board=0, timer=0.
- All outputs are registered or decoded from registered state; no combinational input→output paths.
- `start` high in cycle N (IDLE): GEN in N+1, `gen_req`=1 in N+1 only.
- `board_ready` in cycle M (GEN, nonzero board): `show`=1 in M+1 through M+SHOW_CYCLES inclusive; PLAY from M+SHOW_CYCLES+1.
- Guess accepted in cycle N: CHECK in N+1 (`guess_ready`=0). `found`/`remaining`/`win`/`lose` update in N+2, when state is PLAY/WIN/LOSE. Sustained guessing gives at most one guess per 2 cycles.
- `start` and `guess_valid` together in PLAY: the guess is taken, `start` is ignored.
- Reset asserted mid-round (any state): immediate return to reset values; no partial round survives.

## Structure
- Shared package `memmatrix_pkg`: state encoding (3-bit localparams for IDLE..LOSE) and default constants (CELLS, MAX_GUESSES, SHOW_CYCLES). The same constants are used by the board generator and the display logic.
- Sub-module `phase_timer`: loadable down-counter (`load`, `value`, `done`). Width is $clog2(SHOW_CYCLES+1). Instantiated once, for SHOW.
- Found mask, remaining counter and FSM stay in `game_controller`.

## Test plan
- Reset, then `start`, `board`=16'h0009 ready, SHOW_CYCLES=4 → `gen_req` pulses once; `show` high exactly 4 cycles; `guess_ready` rises the next cycle.
- Guesses 0 then 3 → `found`=0x0001, then 0x0009; `win`=1 two cycles after the second accept; `remaining` stays 3.
- Guesses 1, 2, 4 on board 0x0009 → `remaining` 2, 1, 0; `lose`=1 after the third; no underflow on further `guess_valid`.
- Guess 0 twice, then 1 → second guess 0 leaves `remaining`=3 and `found`=0x0001; guess 1 gives `remaining`=2.
- Generator returns 0x0000 then 0x0100 → two `gen_req` pulses; SHOW entered with 0x0100 latched.
- Reset pulsed during SHOW, and `start` held high during PLAY → immediate IDLE with all outputs at reset values; `start` in PLAY has no effect.
